// File: rtl/can_fd_destuff_if.sv
// Sample-side inputs and CRC-side outputs of the receive destuffer.
interface can_fd_destuff_if;
    logic       sample_point;
    logic       sampled_bit;
    logic       rx_active;
    logic       stuff_en;
    logic       fixed_stuff;
    logic       bit_data;
    logic       bit_valid;
    logic       stuff_bit;
    logic       fixed_stuff_bit;
    logic       stuff_err;
    logic [2:0] stuff_cnt;
    logic [2:0] stuff_cnt_gray;
    logic       stuff_cnt_par;

    // Bit timing / bit stream processor side drives the samples and mode.
    modport master (
        output sample_point, sampled_bit, rx_active, stuff_en, fixed_stuff,
        input  bit_data, bit_valid, stuff_bit, fixed_stuff_bit, stuff_err,
        input  stuff_cnt, stuff_cnt_gray, stuff_cnt_par
    );

    // The destuffer itself.
    modport slave (
        input  sample_point, sampled_bit, rx_active, stuff_en, fixed_stuff,
        output bit_data, bit_valid, stuff_bit, fixed_stuff_bit, stuff_err,
        output stuff_cnt, stuff_cnt_gray, stuff_cnt_par
    );
endinterface

// File: rtl/can_fd_destuff.sv
// CAN / CAN FD receive destuffer: classifies each sampled bit as data,
// dynamic stuff bit or fixed stuff bit, flags stuff errors and keeps the
// dynamic stuff-bit count (binary, Gray and parity) for the FD stuff-count field.
module can_fd_destuff #(
    parameter int STUFF_LEN = 5,
    parameter int FIXED_LEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    can_fd_destuff_if.slave bus
);

    localparam int RUN_W  = $clog2(STUFF_LEN + 1);
    localparam int FCNT_W = $clog2(FIXED_LEN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STUFF_LEN);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FIXED_LEN);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    typedef enum logic [1:0] {
        MODE_PLAIN   = 2'd0,
        MODE_DYNAMIC = 2'd1,
        MODE_FIXED   = 2'd2
    } mode_t;

    // Frame state
    logic              r_last_bit;
    logic [RUN_W-1:0]  r_run;
    logic [FCNT_W-1:0] r_fcnt;
    logic [2:0]        r_cnt;
    logic              r_fixed_seen;

    // Registered outputs
    logic              r_bit_data;
    logic              r_bit_valid;
    logic              r_stuff_bit;
    logic              r_fixed_stuff_bit;
    logic              r_stuff_err;

    // Next-state values
    mode_t             w_mode;
    logic              w_same;
    logic [FCNT_W-1:0] w_fpos;
    logic              w_last_bit_nxt;
    logic [RUN_W-1:0]  w_run_nxt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic [2:0]        w_cnt_nxt;
    logic              w_fixed_seen_nxt;
    logic              w_bit_data_nxt;
    logic              w_bit_valid_nxt;
    logic              w_stuff_bit_nxt;
    logic              w_fixed_stuff_bit_nxt;
    logic              w_stuff_err_nxt;
    logic [2:0]        w_gray;

    // Decode the active stuffing rule from the frame-field qualifiers.
    always_comb begin
        if (!bus.stuff_en) begin
            w_mode = MODE_PLAIN;
        end else if (bus.fixed_stuff) begin
            w_mode = MODE_FIXED;
        end else begin
            w_mode = MODE_DYNAMIC;
        end
    end

    // Classify the current sample and compute the next frame state.
    always_comb begin
        w_last_bit_nxt        = r_last_bit;
        w_run_nxt             = r_run;
        w_fcnt_nxt            = r_fcnt;
        w_cnt_nxt             = r_cnt;
        w_fixed_seen_nxt      = r_fixed_seen;
        w_bit_data_nxt        = r_bit_data;
        w_bit_valid_nxt       = 1'b0;
        w_stuff_bit_nxt       = 1'b0;
        w_fixed_stuff_bit_nxt = 1'b0;
        w_stuff_err_nxt       = 1'b0;
        w_same                = (bus.sampled_bit == r_last_bit);
        // The first fixed-mode sample always lands on a fixed stuff bit,
        // whatever fcnt was left at from earlier fields.
        w_fpos                = r_fixed_seen ? r_fcnt : '0;

        if (!bus.rx_active) begin
            w_last_bit_nxt   = 1'b1;
            w_run_nxt        = '0;
            w_fcnt_nxt       = '0;
            w_cnt_nxt        = '0;
            w_fixed_seen_nxt = 1'b0;
            w_bit_data_nxt   = 1'b0;
        end else if (bus.sample_point) begin
            w_bit_data_nxt = bus.sampled_bit;
            w_last_bit_nxt = bus.sampled_bit;
            case (w_mode)
                MODE_PLAIN: begin
                    w_bit_valid_nxt = 1'b1;
                    w_run_nxt       = '0;
                    w_fcnt_nxt      = '0;
                end
                MODE_DYNAMIC: begin
                    if (r_run == RUN_MAX) begin
                        if (w_same) begin
                            // Violating bit restarts the run so the next
                            // opposite bit is taken as data.
                            w_stuff_err_nxt = 1'b1;
                            w_run_nxt       = RUN_ONE;
                        end else begin
                            w_bit_valid_nxt = 1'b1;
                            w_stuff_bit_nxt = 1'b1;
                            w_cnt_nxt       = r_cnt + 3'd1;
                            w_run_nxt       = RUN_ONE;
                        end
                    end else begin
                        w_bit_valid_nxt = 1'b1;
                        w_run_nxt       = w_same ? (r_run + RUN_ONE) : RUN_ONE;
                    end
                end
                MODE_FIXED: begin
                    w_fixed_seen_nxt = 1'b1;
                    if (w_fpos == '0) begin
                        w_fixed_stuff_bit_nxt = 1'b1;
                        w_stuff_err_nxt       = w_same;
                        w_fcnt_nxt            = FCNT_ONE;
                    end else begin
                        w_bit_valid_nxt = 1'b1;
                        w_fcnt_nxt      = (w_fpos == FCNT_MAX) ? '0 : (w_fpos + FCNT_ONE);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_bit        <= 1'b1;
            r_run             <= '0;
            r_fcnt            <= '0;
            r_cnt             <= '0;
            r_fixed_seen      <= 1'b0;
            r_bit_data        <= 1'b0;
            r_bit_valid       <= 1'b0;
            r_stuff_bit       <= 1'b0;
            r_fixed_stuff_bit <= 1'b0;
            r_stuff_err       <= 1'b0;
        end else begin
            r_last_bit        <= w_last_bit_nxt;
            r_run             <= w_run_nxt;
            r_fcnt            <= w_fcnt_nxt;
            r_cnt             <= w_cnt_nxt;
            r_fixed_seen      <= w_fixed_seen_nxt;
            r_bit_data        <= w_bit_data_nxt;
            r_bit_valid       <= w_bit_valid_nxt;
            r_stuff_bit       <= w_stuff_bit_nxt;
            r_fixed_stuff_bit <= w_fixed_stuff_bit_nxt;
            r_stuff_err       <= w_stuff_err_nxt;
        end
    end

    // Gray-coded stuff count for the FD stuff-count field.
    always_comb begin
        w_gray = r_cnt ^ {1'b0, r_cnt[2:1]};
    end

    assign bus.bit_data        = r_bit_data;
    assign bus.bit_valid       = r_bit_valid;
    assign bus.stuff_bit       = r_stuff_bit;
    assign bus.fixed_stuff_bit = r_fixed_stuff_bit;
    assign bus.stuff_err       = r_stuff_err;
    assign bus.stuff_cnt       = r_cnt;
    assign bus.stuff_cnt_gray  = w_gray;
    assign bus.stuff_cnt_par   = ^w_gray;

endmodule

// File: tb/tb_can_fd_destuff.sv
// Bench for can_fd_destuff: directed sequences with literal expectations plus
// randomized frames checked every cycle against a behavioural model.
module tb_can_fd_destuff;

    localparam int STUFF_LEN = 5;
    localparam int FIXED_LEN = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    can_fd_destuff_if bus ();

    can_fd_destuff #(
        .STUFF_LEN(STUFF_LEN),
        .FIXED_LEN(FIXED_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Run length of equal bits, position inside the fixed-stuff grid, and
    // the stuff count, computed straight from the stuffing rules.
    int m_run     = 0;
    bit m_last    = 1'b1;
    int m_fidx    = 0;
    bit m_seen    = 1'b0;
    int m_cnt     = 0;
    bit e_data    = 1'b0;
    bit e_valid   = 1'b0;
    bit e_stuff   = 1'b0;
    bit e_fixed   = 1'b0;
    bit e_err     = 1'b0;
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    always @(posedge clk or negedge rst_n) begin
        bit b;
        e_valid = 1'b0;
        e_stuff = 1'b0;
        e_fixed = 1'b0;
        e_err   = 1'b0;
        if (!rst_n || !bus.rx_active) begin
            m_run = 0; m_last = 1'b1; m_fidx = 0; m_seen = 1'b0; m_cnt = 0;
            e_data = 1'b0;
        end else if (bus.sample_point) begin
            b = bus.sampled_bit;
            e_data = b;
            if (!bus.stuff_en) begin
                e_valid = 1'b1;
                m_run   = 0;
                m_fidx  = 0;
            end else if (bus.fixed_stuff) begin
                if (!m_seen) m_fidx = 0;
                m_seen = 1'b1;
                if (m_fidx % (FIXED_LEN + 1) == 0) begin
                    e_fixed = 1'b1;
                    e_err   = (b == m_last);
                end else begin
                    e_valid = 1'b1;
                end
                m_fidx++;
            end else if (m_run == STUFF_LEN) begin
                if (b == m_last) begin
                    e_err = 1'b1;
                end else begin
                    e_valid = 1'b1;
                    e_stuff = 1'b1;
                    m_cnt   = (m_cnt + 1) % 8;
                end
                m_run = 1;
            end else begin
                e_valid = 1'b1;
                m_run   = (b == m_last) ? m_run + 1 : 1;
            end
            m_last = b;
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("bit_data",        int'(bus.bit_data),        int'(e_data));
        chk("bit_valid",       int'(bus.bit_valid),       int'(e_valid));
        chk("stuff_bit",       int'(bus.stuff_bit),       int'(e_stuff));
        chk("fixed_stuff_bit", int'(bus.fixed_stuff_bit), int'(e_fixed));
        chk("stuff_err",       int'(bus.stuff_err),       int'(e_err));
        chk("stuff_cnt",       int'(bus.stuff_cnt),       m_cnt);
        chk("stuff_cnt_gray",  int'(bus.stuff_cnt_gray),  gray_tab[m_cnt]);
        chk("stuff_cnt_par",   int'(bus.stuff_cnt_par),   $countones(gray_tab[m_cnt]) % 2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit b);
        @(negedge clk);
        bus.sampled_bit  = b;
        bus.sample_point = 1'b1;
        @(negedge clk);
        bus.sample_point = 1'b0;
    endtask

    task automatic clear_frame();
        @(negedge clk);
        bus.sample_point = 1'b0;
        bus.rx_active    = 1'b0;
        bus.fixed_stuff  = 1'b0;
        bus.stuff_en     = 1'b1;
        @(negedge clk);
        bus.rx_active    = 1'b1;
    endtask

    task automatic chk_strobe(input string name, input bit v, input bit s, input bit f, input bit e);
        chk({name, ".bit_valid"},       int'(bus.bit_valid),       int'(v));
        chk({name, ".stuff_bit"},       int'(bus.stuff_bit),       int'(s));
        chk({name, ".fixed_stuff_bit"}, int'(bus.fixed_stuff_bit), int'(f));
        chk({name, ".stuff_err"},       int'(bus.stuff_err),       int'(e));
    endtask

    initial begin
        bit cur;
        bit b;
        n_tests = 0;
        n_fail  = 0;
        rst_n            = 1'b0;
        bus.sample_point = 1'b0;
        bus.sampled_bit  = 1'b1;
        bus.rx_active    = 1'b0;
        bus.stuff_en     = 1'b0;
        bus.fixed_stuff  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.bit_valid", int'(bus.bit_valid), 0);
        chk("reset.stuff_cnt", int'(bus.stuff_cnt), 0);
        chk("reset.bit_data",  int'(bus.bit_data),  0);
        rst_n         = 1'b1;
        bus.rx_active = 1'b1;
        bus.stuff_en  = 1'b1;

        // Five dominant bits then a recessive dynamic stuff bit.
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            chk_strobe("t1.data", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        send(1'b1);
        chk_strobe("t1.stuff", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1.bit_data",  int'(bus.bit_data),       1);
        chk("t1.stuff_cnt", int'(bus.stuff_cnt),      1);
        chk("t1.gray",      int'(bus.stuff_cnt_gray), 1);
        chk("t1.par",       int'(bus.stuff_cnt_par),  1);

        // Six recessive bits after a dominant SOF: stuff error on the sixth.
        clear_frame();
        send(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1);
        chk_strobe("t2.fifth", 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1);
        chk_strobe("t2.err", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2.err_one_clk", int'(bus.stuff_err), 0);
        send(1'b0);
        chk_strobe("t2.after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Eleven dynamic stuff bits, then fixed stuffing freezes the count.
        clear_frame();
        cur = 1'b0;
        repeat (5) send(cur);
        for (int k = 0; k < 11; k++) begin
            cur = ~cur;
            send(cur);
            chk("t3.stuff_bit", int'(bus.stuff_bit), 1);
            if (k < 10) repeat (4) send(cur);
        end
        chk("t3.stuff_cnt", int'(bus.stuff_cnt),      3);
        chk("t3.gray",      int'(bus.stuff_cnt_gray), 2);
        chk("t3.par",       int'(bus.stuff_cnt_par),  1);
        bus.fixed_stuff = 1'b1;
        b = ~cur;
        for (int k = 0; k < 2; k++) begin
            send(b);
            chk_strobe("t3.fixed", 1'b0, 1'b0, 1'b1, 1'b0);
            repeat (4) send(b);
            b = ~b;
        end
        chk("t3.frozen_cnt",  int'(bus.stuff_cnt),      3);
        chk("t3.frozen_gray", int'(bus.stuff_cnt_gray), 2);

        // Dropping rx_active clears the count; restart needs five more zeros.
        clear_frame();
        chk("t5.cnt_cleared", int'(bus.stuff_cnt), 0);
        repeat (3) send(1'b0);
        clear_frame();
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            chk_strobe("t5.zero", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("t5.stuff_cnt", int'(bus.stuff_cnt), 0);
        send(1'b1);
        chk_strobe("t5.stuff", 1'b1, 1'b1, 1'b0, 1'b0);

        // Fixed stuff grid: stuff, four data, stuff; then a bad fixed stuff bit.
        for (int rep = 0; rep < 2; rep++) begin
            clear_frame();
            send(1'b0);
            send(1'b1);
            bus.fixed_stuff = 1'b1;
            send(1'b0);
            chk_strobe("t4.first", 1'b0, 1'b0, 1'b1, 1'b0);
            send(1'b1); chk_strobe("t4.d1", 1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b0); chk_strobe("t4.d2", 1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b1); chk_strobe("t4.d3", 1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b1); chk_strobe("t4.d4", 1'b1, 1'b0, 1'b0, 1'b0);
            send(rep[0]);
            chk_strobe("t4.sixth", 1'b0, 1'b0, 1'b1, rep[0]);
        end

        // Asynchronous reset between sample strobe and output clock.
        clear_frame();
        send(1'b1);
        chk("t6.pre_valid", int'(bus.bit_valid), 1);
        bus.sampled_bit  = 1'b0;
        bus.sample_point = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_strobe("t6.async", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.bit_data", int'(bus.bit_data), 0);
        @(negedge clk);
        bus.sample_point = 1'b0;
        chk("t6.lost_strobe", int'(bus.bit_valid), 0);
        rst_n         = 1'b1;
        bus.rx_active = 1'b0;
        send(1'b1);
        chk_strobe("t6.rx_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized frames: dynamic, then fixed, then unstuffed segment.
        for (int f = 0; f < 60; f++) begin
            @(negedge clk);
            bus.sample_point = 1'b0;
            bus.rx_active    = 1'b0;
            bus.stuff_en     = 1'b1;
            bus.fixed_stuff  = 1'b0;
            repeat ($urandom_range(2, 0)) @(negedge clk);
            bus.rx_active = 1'b1;
            cur = 1'b0;
            for (int seg = 0; seg < 3; seg++) begin
                int len;
                bus.stuff_en    = (seg != 2);
                bus.fixed_stuff = (seg == 1);
                len = (seg == 0) ? int'($urandom_range(60, 10)) : int'($urandom_range(20, 0));
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    if ($urandom_range(5, 0) == 0) cur = ~cur;
                    bus.sampled_bit  = cur;
                    bus.sample_point = ($urandom_range(2, 0) != 0);
                end
            end
        end
        @(negedge clk);
        bus.sample_point = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/can_fd_destuff.md
Name: can_fd_destuff

Overview:
Receive-side bit destuffer for the classic CAN / CAN FD bit stream processor. It sits between the bit-timing sample logic and the CRC calculator. It consumes one sampled bus bit per sample strobe and classifies each bit as data, dynamic stuff bit or fixed stuff bit. It drives the CRC calculator's data, stuff-bit and enable inputs, detects stuff errors, and keeps the ISO FD dynamic stuff-bit count for the stuff-count field check.

Parameters:
STUFF_LEN, 5, number of equal consecutive bits after which a dynamic stuff bit is expected
FIXED_LEN, 4, number of data bits between fixed stuff bits in the FD CRC field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
sample_point  in  1  one-cycle strobe, one per bit time
sampled_bit  in  1  bus value at sample point (0 = dominant)
rx_active  in  1  high from SOF sample until end of frame; low clears frame state
stuff_en  in  1  stuffing rules active (SOF through CRC sequence)
fixed_stuff  in  1  FD CRC field: fixed stuffing replaces dynamic stuffing
bit_data  out  1  destuffed/classified bit value (to CRC data)
bit_valid  out  1  one-cycle strobe: bit goes to CRC enable (data or dynamic stuff bit)
stuff_bit  out  1  qualifies bit_valid: bit is a dynamic stuff bit
fixed_stuff_bit  out  1  one-cycle strobe: fixed stuff bit consumed; bit_valid stays 0
stuff_err  out  1  one-cycle pulse: stuff rule violation
stuff_cnt  out  3  dynamic stuff bits mod 8
stuff_cnt_gray  out  3  Gray code of stuff_cnt
stuff_cnt_par  out  1  even parity over stuff_cnt_gray (XOR of its 3 bits)

Behaviour:
- Reset value: all outputs 0. Internal state: last_bit=1, run=0, fcnt=0, cnt=0, fixed_seen=0.
- Latency: all outputs are registered and appear exactly 1 clk after the sample_point cycle. With no sample_point, strobes are 0 and data outputs hold their value.
- Priority: rst_n, then rx_active low, then sample processing.
- rx_active low: state is cleared to the reset values on each clk and sample_point is ignored. stuff_cnt is cleared too.
- Dynamic mode (stuff_en=1, fixed_stuff=0), on each sample_point:
  - run==STUFF_LEN and sampled_bit==last_bit: pulse stuff_err; bit_valid=0.
  - run==STUFF_LEN and sampled_bit!=last_bit: this is a stuff bit. bit_valid=1, stuff_bit=1, cnt+=1 (wraps 7 to 0), run=1.
  - Otherwise, a data bit: bit_valid=1, stuff_bit=0. Set run=run+1 if sampled_bit==last_bit, else run=1.
  - In every case last_bit=sampled_bit.
  - The SOF bit counts: the first sample after rx_active rises gives run=1.
- Fixed mode (stuff_en=1, fixed_stuff=1):
  - On the first sample with fixed_stuff=1, set fcnt=0 and fixed_seen=1, and freeze cnt.
  - fcnt==0: a fixed stuff bit is expected. The first one comes immediately, including when run==STUFF_LEN at the switch. If sampled_bit==~last_bit: fixed_stuff_bit=1, bit_valid=0. Otherwise pulse stuff_err (fixed_stuff_bit still pulses). Then fcnt=1.
  - fcnt 1..FIXED_LEN: data bit. bit_valid=1, stuff_bit=0. fcnt increments; it goes to 0 after the FIXED_LEN-th data bit.
  - last_bit=sampled_bit every sample. The run counter is not evaluated.
- stuff_en=0: every sample is a data bit (bit_valid=1, stuff_bit=0) with no checks. run=0, fcnt=0; last_bit still tracks the bus.
- stuff_cnt_gray mapping: 0→000, 1→001, 2→011, 3→010, 4→110, 5→111, 6→101, 7→100.
- stuff_cnt_par = ^stuff_cnt_gray. stuff_cnt, stuff_cnt_gray and stuff_cnt_par are combinational from the cnt register.
- After stuff_err, processing continues. The bit stream processor is responsible for the error frame.
- rst_n asserted mid-frame: all outputs are 0 immediately (asynchronous). A pending strobe is lost.

Test Plan:
1. rx_active=1, stuff_en=1; samples 0,0,0,0,0,1 → strobes 1–5 bit_valid=1 stuff_bit=0; strobe 6 bit_valid=1 stuff_bit=1 bit_data=1; stuff_cnt=1, gray=001, par=1.
2. Samples 1,1,1,1,1,1 after a dominant SOF → 6th sample gives stuff_err pulse for exactly 1 clk, bit_valid=0; the next 0 sample is accepted as a data bit with run=1.
3. Force 11 dynamic stuff bits → stuff_cnt=3, gray=010, par=1. Then assert fixed_stuff and insert 2 more stuff-like patterns → stuff_cnt stays 3.
4. Last bit before fixed_stuff = 1; samples 0 (fixed stuff), 1,0,1,1, then 0 → fixed_stuff_bit at 1st and 6th strobes, bit_valid=0 on both, 4 bit_valid=1 in between. Repeat with 6th sample=1 → stuff_err.
5. Drop rx_active after 3 equal bits, then restart with SOF=0 plus 4 zeros → no stuff expected until after the 5th zero; stuff_cnt=0 at restart.
6. Assert rst_n=0 between sample_point and the output clk → all outputs 0 asynchronously. After release, first sample_point with rx_active=0 → no strobes.
